// File: rtl/sparse_row_accumulator.sv
// sparse_row_accumulator
// Consumer side of the CSR weight/bias stream for the time-multiplexed p-bit
// core. A row request is passed to the row loader. The streamed sparse row is
// accumulated against the p-bit state vector as I = h + sum(w_j * m_j), with
// m_j in {+1,-1}. The field is saturated to I_WIDTH and returned with a
// compute_done pulse that releases the loader.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   row_start, row_sel row request (sampled in IDLE only) and row number
//   pbit_state         bit j = 1 -> m_j = +1, 0 -> m_j = -1; stable while busy
//   start_load         one-cycle request to the loader
//   current_row        latched row_sel
//   data_valid, value, index   streamed weight beats
//   row_length, h, load_done   loader entry count, row bias, end of row
//   compute_done, I_valid      one-cycle completion pulses
//   I_out              saturated local field, held until the next result
//   busy               from accepted request through completion
//   idx_err, len_err   sticky per-row errors, cleared on the next request
//
// state  | meaning
// IDLE   | waiting for row_start (only taken once busy has dropped)
// ACCUM  | consuming data_valid beats until load_done
// FINISH | add bias, saturate, check length, pulse compute_done
module sparse_row_accumulator #(
  parameter int num_Pbits   = 16,
  parameter int VAL_WIDTH   = 8,
  parameter int INDEX_WIDTH = 5,
  parameter int h_WIDTH     = 8,
  parameter int I_WIDTH     = 10,
  localparam int ROW_W      = $clog2(num_Pbits + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          row_start,
  input  logic [ROW_W-1:0]              row_sel,
  input  logic [num_Pbits-1:0]          pbit_state,
  output logic                          start_load,
  output logic [ROW_W-1:0]              current_row,
  input  logic                          data_valid,
  input  logic signed [VAL_WIDTH-1:0]   value,
  input  logic [INDEX_WIDTH-1:0]        index,
  input  logic [4:0]                    row_length,
  input  logic signed [h_WIDTH-1:0]     h,
  input  logic                          load_done,
  output logic                          compute_done,
  output logic signed [I_WIDTH-1:0]     I_out,
  output logic                          I_valid,
  output logic                          busy,
  output logic                          idx_err,
  output logic                          len_err
);

  localparam int ACC_W = ((VAL_WIDTH > h_WIDTH) ? VAL_WIDTH : h_WIDTH)
                         + $clog2(num_Pbits) + 2;
  localparam int SEL_W = (num_Pbits > 1) ? $clog2(num_Pbits) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (I_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (I_WIDTH - 1)));

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic signed [I_WIDTH-1:0] iout_q, iout_d;
  logic                      start_q, start_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      idx_err_q, idx_err_d;
  logic                      len_err_q, len_err_d;

  logic signed [ACC_W-1:0]   value_ext, h_ext, sum;
  logic                      idx_ok;
  logic                      m_bit;

  assign value_ext = ACC_W'(value);
  assign h_ext     = ACC_W'(h);
  assign sum       = acc_q + h_ext;
  assign idx_ok    = ({{(32 - INDEX_WIDTH){1'b0}}, index} < 32'(num_Pbits));
  // Only meaningful when idx_ok; out-of-range indices never reach the adder.
  assign m_bit     = pbit_state[index[SEL_W-1:0]];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    iout_d    = iout_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    idx_err_d = idx_err_q;
    len_err_d = len_err_q;
    case (state_q)
      S_IDLE: begin
        // busy is still high during the compute_done cycle; it drops here
        // and a new request is taken only once it has fallen.
        busy_d = 1'b0;
        if (row_start && !busy_q) begin
          row_d     = row_sel;
          start_d   = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
          idx_err_d = 1'b0;
          len_err_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (data_valid) begin
          cnt_d = cnt_q + 5'd1;
          if (!idx_ok)    idx_err_d = 1'b1;
          else if (m_bit) acc_d = acc_q + value_ext;
          else            acc_d = acc_q - value_ext;
        end
        if (load_done) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (sum > SAT_MAX)      iout_d = I_WIDTH'(SAT_MAX);
        else if (sum < SAT_MIN) iout_d = I_WIDTH'(SAT_MIN);
        else                    iout_d = I_WIDTH'(sum);
        if (cnt_q != row_length) len_err_d = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
      iout_q    <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      idx_err_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      iout_q    <= iout_d;
      start_q   <= start_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      idx_err_q <= idx_err_d;
      len_err_q <= len_err_d;
    end
  end

  assign start_load   = start_q;
  assign current_row  = row_q;
  assign compute_done = done_q;
  assign I_valid      = done_q;
  assign I_out        = iout_q;
  assign busy         = busy_q;
  assign idx_err      = idx_err_q;
  assign len_err      = len_err_q;

endmodule
